// File: rtl/mgnt_reg_resp_pkg.sv
// Shared management-bus definitions: address map, FSM encoding and decode helpers
// used by the register responder and its bus interface.
package mgnt_reg_resp_pkg;

  localparam int ADDR_W    = 8;
  localparam int BYTE_W    = 8;
  localparam int REG_COUNT = 8;
  localparam int IDX_W     = $clog2(REG_COUNT);

  localparam logic [ADDR_W-1:0] CTRL_BASE = 8'h00;
  localparam logic [ADDR_W-1:0] STAT_BASE = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_SEND = 3'd1,
    ST_WR_RECV = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // True when addr falls inside the REG_COUNT-entry window starting at base.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base);
    return (addr >= base) && ((addr - base) < ADDR_W'(REG_COUNT));
  endfunction

  function automatic logic [IDX_W-1:0] win_index(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] base);
    return IDX_W'(addr - base);
  endfunction

  function automatic logic [REG_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    return REG_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/mgnt_reg_resp_if.sv
// Byte-serial management request/response bus between the hub (master)
// and a register target (slave).
interface mgnt_reg_resp_if;
  import mgnt_reg_resp_pkg::*;

  logic              sys_req_valid;
  logic              sys_req_wr;
  logic [ADDR_W-1:0] sys_req_addr;
  logic              sys_req_ack;
  logic [BYTE_W-1:0] sys_req_data;
  logic              sys_req_data_valid;
  logic [BYTE_W-1:0] sys_resp_data;
  logic              sys_resp_data_valid;

  modport master (
    output sys_req_valid, sys_req_wr, sys_req_addr, sys_req_data, sys_req_data_valid,
    input  sys_req_ack, sys_resp_data, sys_resp_data_valid
  );

  modport slave (
    input  sys_req_valid, sys_req_wr, sys_req_addr, sys_req_data, sys_req_data_valid,
    output sys_req_ack, sys_resp_data, sys_resp_data_valid
  );

endinterface

// File: rtl/mgnt_reg_resp.sv
// Management register target: eight RW control words and eight RO status words,
// transferred MSB byte first over the byte-serial request/response bus.
module mgnt_reg_resp
  import mgnt_reg_resp_pkg::*;
#(
  parameter int                        MGNT_REG_WIDTH = 32,
  parameter logic [MGNT_REG_WIDTH-1:0] CTRL_RST_VAL   = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  mgnt_reg_resp_if.slave                      sys,
  output logic [REG_COUNT*MGNT_REG_WIDTH-1:0] ctrl_reg,
  output logic [REG_COUNT-1:0]                ctrl_wr_stb,
  input  logic [REG_COUNT*MGNT_REG_WIDTH-1:0] status_reg,
  output logic [REG_COUNT-1:0]                status_rd_stb
);

  localparam int NB   = MGNT_REG_WIDTH / BYTE_W;
  localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_e                    r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_wr;
  logic [CW-1:0]             r_cnt;
  logic [MGNT_REG_WIDTH-1:0] r_tx_shift;
  logic [MGNT_REG_WIDTH-1:0] r_rx_shift;
  logic [BYTE_W-1:0]         r_resp_data;
  logic                      r_resp_valid;
  logic                      r_ack;
  logic [REG_COUNT-1:0]      r_ctrl_wr_stb;
  logic [REG_COUNT-1:0]      r_status_rd_stb;
  logic [MGNT_REG_WIDTH-1:0] r_ctrl [REG_COUNT];

  logic                      w_req_stat_hit;
  logic                      w_req_ctrl_hit;
  logic                      w_wr_ctrl_hit;
  logic [MGNT_REG_WIDTH-1:0] w_rd_word;
  logic [MGNT_REG_WIDTH-1:0] w_rx_word;

  assign w_req_stat_hit = in_window(sys.sys_req_addr, STAT_BASE);
  assign w_req_ctrl_hit = in_window(sys.sys_req_addr, CTRL_BASE);
  assign w_wr_ctrl_hit  = r_wr && in_window(r_addr, CTRL_BASE);
  assign w_rx_word      = (r_rx_shift << BYTE_W) | MGNT_REG_WIDTH'(sys.sys_req_data);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_rd_word = '0;
    if (w_req_stat_hit)
      w_rd_word = status_reg[win_index(sys.sys_req_addr, STAT_BASE)*MGNT_REG_WIDTH +: MGNT_REG_WIDTH];
    else if (w_req_ctrl_hit)
      w_rd_word = r_ctrl[win_index(sys.sys_req_addr, CTRL_BASE)];
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_ctrl_flat
    assign ctrl_reg[g*MGNT_REG_WIDTH +: MGNT_REG_WIDTH] = r_ctrl[g];
  end

  assign sys.sys_req_ack         = r_ack;
  assign sys.sys_resp_data       = r_resp_data;
  assign sys.sys_resp_data_valid = r_resp_valid;
  assign ctrl_wr_stb             = r_ctrl_wr_stb;
  assign status_rd_stb           = r_status_rd_stb;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_wr            <= 1'b0;
      r_cnt           <= '0;
      r_tx_shift      <= '0;
      r_rx_shift      <= '0;
      r_resp_data     <= '0;
      r_resp_valid    <= 1'b0;
      r_ack           <= 1'b0;
      r_ctrl_wr_stb   <= '0;
      r_status_rd_stb <= '0;
      // NOTE: the control array is software-visible state, so it is reset
      // explicitly; it is a handful of flops, not a RAM.
      for (int i = 0; i < REG_COUNT; i++) r_ctrl[i] <= CTRL_RST_VAL;
    end else begin
      r_ack           <= 1'b0;
      r_ctrl_wr_stb   <= '0;
      r_status_rd_stb <= '0;

      unique case (r_state)
        ST_IDLE: begin
          if (sys.sys_req_valid) begin
            r_addr     <= sys.sys_req_addr;
            r_wr       <= sys.sys_req_wr;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            if (!sys.sys_req_wr) begin
              r_resp_data  <= w_rd_word[MGNT_REG_WIDTH-1 -: BYTE_W];
              r_tx_shift   <= w_rd_word << BYTE_W;
              r_resp_valid <= 1'b1;
              if (w_req_stat_hit)
                r_status_rd_stb <= onehot(win_index(sys.sys_req_addr, STAT_BASE));
              r_state <= ST_RD_SEND;
            end else begin
              r_state <= ST_WR_RECV;
            end
          end
        end

        ST_RD_SEND: begin
          if (!sys.sys_req_valid) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_tx_shift   <= '0;
            r_cnt        <= '0;
            r_state      <= ST_IDLE;
          end else if (r_cnt == LAST) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_ack        <= 1'b1;
            r_state      <= ST_ACK;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_resp_data <= r_tx_shift[MGNT_REG_WIDTH-1 -: BYTE_W];
            r_tx_shift  <= r_tx_shift << BYTE_W;
          end
        end

        ST_WR_RECV: begin
          if (!sys.sys_req_valid) begin
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_state    <= ST_IDLE;
          end else if (sys.sys_req_data_valid) begin
            r_rx_shift <= w_rx_word;
            if (r_cnt == LAST) begin
              // RO and unmapped targets still complete, but leave no trace.
              if (w_wr_ctrl_hit) begin
                r_ctrl[win_index(r_addr, CTRL_BASE)] <= w_rx_word;
                r_ctrl_wr_stb <= onehot(win_index(r_addr, CTRL_BASE));
              end
              r_cnt   <= '0;
              r_ack   <= 1'b1;
              r_state <= ST_ACK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_ACK: r_state <= ST_RELEASE;

        ST_RELEASE: begin
          if (!sys.sys_req_valid) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mgnt_reg_resp.md
MGNT_REG_RESP -- requirements
Module: mgnt_reg_resp

Interface
REQ-001 Parameter: MGNT_REG_WIDTH, default 32, register width in bits; must be a multiple of 8; NB = MGNT_REG_WIDTH/8 bytes per transfer.
REQ-002 Parameter: CTRL_RST_VAL, default 0, reset value of every control register.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 sys_req_valid  in  1  this target's bit of the hub one-hot select; held high for the whole transaction.
REQ-007 sys_req_wr  in  1  1 = write, 0 = read; valid while sys_req_valid is high.
REQ-008 sys_req_addr  in  8  register address; valid while sys_req_valid is high.
REQ-009 sys_req_ack  out  1  one-cycle completion pulse.
REQ-010 sys_req_data  in  8  write byte, MSB byte first.
REQ-011 sys_req_data_valid  in  1  write byte strobe.
REQ-012 sys_resp_data  out  8  read byte, MSB byte first, registered.
REQ-013 sys_resp_data_valid  out  1  read byte strobe, registered.
REQ-014 ctrl_reg  out  8*MGNT_REG_WIDTH  eight RW control registers, flattened; index i at [i*W +: W].
REQ-015 ctrl_wr_stb  out  8  one-hot, one-cycle pulse when control register i is written.
REQ-016 status_reg  in  8*MGNT_REG_WIDTH  eight RO status words, flattened.
REQ-017 status_rd_stb  out  8  one-hot, one-cycle pulse when status word i is sampled (used for clear-on-read).

Function
REQ-018 Address map: 0x00-0x07 are RW ctrl_reg[0..7]; 0x10-0x17 are RO status_reg[0..7]; all other addresses are unmapped.
REQ-019 FSM states: IDLE, RD_SEND, WR_RECV, ACK, RELEASE.
REQ-020 IDLE: when sys_req_valid=1, latch sys_req_addr and sys_req_wr; go to RD_SEND if the request is a read, otherwise go to WR_RECV.
REQ-021 Read (T0 = first IDLE cycle with valid high): at T0, load the addressed word into the TX shift register. An unmapped address loads 0.
REQ-022 Read strobe: status_rd_stb[i] pulses at T0+1 if and only if the address is 0x10+i.
REQ-023 RD_SEND: sys_resp_data_valid is high for exactly NB consecutive cycles, T0+1 to T0+NB. sys_resp_data carries the MSB byte first and shifts left 8 bits per cycle.
REQ-024 After the last read byte, go to ACK; sys_req_ack is high at T0+NB+1 for exactly one cycle.
REQ-025 WR_RECV: each cycle with sys_req_data_valid=1 shifts sys_req_data into the RX register LSB-side and increments the byte counter. Idle gaps between bytes are tolerated.
REQ-026 On receipt of the NB-th byte (cycle Tn), at Tn+1: ctrl_reg[i] takes the assembled word, ctrl_wr_stb[i] pulses, and sys_req_ack pulses. RO and unmapped addresses are discarded but still acknowledged; ctrl_wr_stb stays 0 for them.
REQ-027 ACK: the FSM goes to RELEASE after one cycle.
REQ-028 RELEASE: stay until sys_req_valid=0, then return to IDLE. A single request never produces a second transaction.
REQ-029 Abort: if sys_req_valid falls during RD_SEND or WR_RECV, return to IDLE next cycle. Clear sys_resp_data_valid and the counters. No ctrl_reg update, no ack.
REQ-030 sys_req_data_valid outside WR_RECV is ignored. Extra bytes beyond NB are ignored.
REQ-031 The byte counter is $clog2(NB) bits wide and resets to 0 on entry to RD_SEND and WR_RECV.

Reset
REQ-032 Reset values while rst=0: FSM IDLE; sys_req_ack=0; sys_resp_data_valid=0; sys_resp_data=0; ctrl_reg all CTRL_RST_VAL; ctrl_wr_stb=0; status_rd_stb=0; counters and shift registers 0.
REQ-033 Reset asserted mid-transaction wins over all other activity. After release the block is in IDLE; if sys_req_valid is then high, a new transaction starts.

Structure
REQ-034 Address map constants (CTRL_BASE 0x00, STAT_BASE 0x10, register count 8) and FSM state encodings belong in the shared management package.
REQ-035 No sub-module; the block is a single module.

Verification
REQ-036 Write: valid=1, wr=1, addr=0x03, bytes 0x12,0x34,0x56,0x78 -> ctrl_reg[3]=0x12345678 one cycle after the 4th byte; ctrl_wr_stb=0x08 for one cycle; one ack pulse.
REQ-037 Read: status_reg[5]=0xCAFEF00D, read addr 0x15 -> resp bytes CA,FE,F0,0D on T0+1..T0+4; status_rd_stb=0x20 at T0+1; ack at T0+5.
REQ-038 Unmapped: write addr 0x40 -> no ctrl change, ctrl_wr_stb=0, ack pulses. Read addr 0x40 -> four 0x00 bytes, then ack.
REQ-039 Abort: write addr 0x01, valid drops after 2 bytes -> ctrl_reg[1] unchanged, no ack, IDLE next cycle; a following full write succeeds.
REQ-040 Hold: valid held 5 cycles after ack -> exactly one ack pulse, no second transaction. Write with a 3-cycle gap between bytes 2 and 3 -> correct word written.
REQ-041 Reset: rst=0 during RD_SEND -> sys_resp_data_valid=0 next cycle, all ctrl_reg=CTRL_RST_VAL.
